// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, programmable almost flags, error pulses
// and a selectable standard or first-word-fall-through read port.
module sync_fifo_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter bit          FWFT     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     winc,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rinc,
  output logic [WIDTH-1:0]         rdata,
  output logic                     wfull,
  output logic                     rempty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wfull_q, wfull_d;
  logic          rempty_q, rempty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc;
  logic          rd_acc;

  // Acceptance is judged against the flags registered before this edge.
  assign wr_acc = winc && !wfull_q;
  assign rd_acc = rinc && !rempty_q;

  always_comb begin
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    count_d  = count_q;
    if (wr_acc) waddr_d = AW'(waddr_q + AW'(1));
    if (rd_acc) raddr_d = AW'(raddr_q + AW'(1));
    if (wr_acc && !rd_acc) count_d = CW'(count_q + CW'(1));
    else if (rd_acc && !wr_acc) count_d = CW'(count_q - CW'(1));
    // Flags are registered from the next count so they stay glitch-free.
    wfull_d  = (count_d == CW'(DEPTH));
    rempty_d = (count_d == CW'(0));
    afull_d  = (count_d >= CW'(AF_LEVEL));
    aempty_d = (count_d <= CW'(AE_LEVEL));
    ovf_d    = winc && wfull_q;
    udf_d    = rinc && rempty_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      waddr_q  <= '0;
      raddr_q  <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[waddr_q] <= wdata;
  end

  generate
    if (FWFT) begin : g_fwft
      assign rdata = mem[raddr_q];
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       rdata_q <= '0;
        else if (rd_acc) rdata_q <= mem[raddr_q];
      end
      assign rdata = rdata_q;
    end
  endgenerate

  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Parametrised single-clock FIFO for same-domain buffering between producer and consumer stages. It carries the team's FIFO family forward with an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. Storage is an internal register array, so no separate RAM instance is needed.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

- clk  input  1  single clock; all state changes on the rising edge
- rstn  input  1  reset, asynchronous assert and active-low; release assumed synchronous to clk
- winc  input  1  write request
- wdata  input  WIDTH  write data, sampled on an accepted write
- rinc  input  1  read request or pop
- rdata  output  WIDTH  read data
- wfull  output  1  count == DEPTH
- rempty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: a write was rejected
- underflow  output  1  one-cycle pulse: a read was rejected

## Operation
- Accepted write: winc && !wfull. Stores wdata at mem[waddr]; waddr increments and wraps from DEPTH-1 to 0.
- Accepted read: rinc && !rempty. raddr increments and wraps from DEPTH-1 to 0.
- Acceptance uses the flag values from before the edge.
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle.
- count next value:
  - +1 for a write-only accept.
  - −1 for a read-only accept.
  - Unchanged when both or neither are accepted.
- wfull, rempty, almost_full and almost_empty are decoded from registered count only. They are glitch-free and change only after a clock edge.
- Standard mode (FWFT=0):
  - rdata is a register loaded with mem[raddr] on an accepted read.
  - Otherwise rdata holds its value, including after a rejected read.
- FWFT mode (FWFT=1):
  - rdata = mem[raddr] combinationally. It is valid whenever rempty==0.
  - An accepted rinc pops the current word. The next word appears after that edge.
  - When empty, rdata shows stale array contents and carries no meaning.
- overflow: registered, high for exactly one cycle after any edge where winc && wfull.
- underflow: registered, high for exactly one cycle after any edge where rinc && rempty.
- Reset (rstn low, asynchronous):
  - waddr=0, raddr=0, count=0.
  - rempty=1, wfull=0, almost_empty=1, almost_full=(AF_LEVEL==0 → never; always 0 at reset).
  - overflow=0, underflow=0, standard-mode rdata=0.
  - Array contents are not reset.
- Reset asserted mid-operation discards all stored words immediately. The first operation after release behaves as from empty.

## Timing
- Write at edge N: count, rempty and almost flags reflect it from edge N onward. The word is readable in the cycle after N.
- Standard read accepted at edge N: rdata is valid after edge N (1-cycle latency).
- FWFT: a word written at edge N appears on rdata after edge N, with rempty low.
- Full throughput: one write and one read per cycle sustained at any occupancy 1..DEPTH-1.
- Simultaneous accepted write and read at count=k leave count=k. waddr≠raddr is guaranteed unless k==0 or k==DEPTH, which cannot occur here.
- Error pulses lag the offending request by one edge and never stretch beyond one cycle unless the request repeats.

## Test plan
- Reset: drive rstn=0 mid-burst with count=5 -> outputs immediately show count=0, rempty=1, wfull=0, almost_empty=1, overflow=underflow=0; after release, write 0xA5 then read -> rdata=0xA5.
- Fill (DEPTH=16): write 0x00..0x0F -> almost_full rises when count=14, wfull=1 at count=16; a 17th winc gives overflow=1 for one cycle, count stays 16, and data is unchanged.
- Drain in standard mode: 16 reads -> rdata=0x00..0x0F, each one cycle after its accept; almost_empty rises at count=2, rempty=1 at 0; an extra rinc gives underflow=1 and rdata holds 0x0F.
- Simultaneous at boundaries:
  - Full with winc+rinc -> read accepted, write rejected, overflow pulse, count=15.
  - Empty with winc+rinc -> write accepted, underflow pulse, count=1.
- Wrap-around: run 40 cycles of concurrent write/read at count=3 with incrementing data -> output sequence in order with no loss, count constant at 3, and addresses wrap at least twice.
- FWFT=1: write 0x11, 0x22 -> rdata=0x11 after the first write edge; pop -> rdata=0x22; pop -> rempty=1.
